// File: rtl/led_disp_pkg.sv
// Shared seven-segment definitions for the scanned LED display blocks.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package led_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } disp_state_e;

  // Non-decimal nibbles (A-F) render blank; 4'hF is the explicit blank code.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder.
module seg7_decode
  import led_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(nib);

endmodule

// File: rtl/led_scan_countdown.sv
// Multiplexed seven-segment scan controller with a BCD countdown field in
// the top digits, start/pause control and a repeat count.
module led_scan_countdown
  import led_disp_pkg::*;
#(
  parameter int                        NUM_DIGITS  = 8,
  parameter int                        SCAN_CYCLES = 4,
  parameter int                        TICK_CYCLES = 32,
  parameter int                        CNT_DIGITS  = 2,
  parameter logic [4*CNT_DIGITS-1:0]   CNT_INIT    = 8'h10,
  parameter int                        REPEAT      = 2,
  parameter logic [4*NUM_DIGITS-1:0]   STATIC_BCD  = 32'h00201028,
  parameter bit                        BLANK_LZ    = 1'b0,
  parameter logic [NUM_DIGITS-1:0]     DP_MASK     = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_start,
  input  logic                  btn_pause,
  output logic [NUM_DIGITS-1:0] led_en,
  output logic [6:0]            led_seg,
  output logic                  led_dp,
  output logic                  running,
  output logic                  done
);

  localparam int CW = 4 * CNT_DIGITS;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int LO = NUM_DIGITS - CNT_DIGITS;

  disp_state_e   state_q, state_d;
  logic          start_q, pause_q, start_e, pause_e;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          run_cyc, tick;

  logic [DW-1:0] dig_q, nxt_idx;
  logic [SW-1:0] scan_q;
  logic          entering, scan_act, load;
  logic [NUM_DIGITS-1:0][3:0] disp_nib;
  logic [CNT_DIGITS-1:0]      lz_blank;
  logic [3:0]    sel_nib;
  logic [6:0]    sel_seg;

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_e = btn_start & ~start_q;
  assign pause_e = btn_pause & ~pause_q;

  // A cycle that carries a button edge is spent on the control action,
  // so the tick counter only advances on quiet RUN cycles.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pass_d  = pass_q;
    tick_d  = tick_q;
    run_cyc = (state_q == ST_RUN) && !start_e && !pause_e;
    tick    = run_cyc && (tick_q == TW'(TICK_CYCLES - 1));
    if (start_e) begin
      state_d = ST_RUN;
      count_d = CNT_INIT;
      pass_d  = '0;
      tick_d  = '0;
    end else if (pause_e && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (pause_e && state_q == ST_PAUSE) begin
      state_d = ST_RUN;
    end else if (run_cyc) begin
      tick_d = tick ? '0 : tick_q + 1'b1;
      if (tick) begin
        if (count_q != '0)                    count_d = bcd_dec(count_q);
        else if (pass_q != PW'(REPEAT - 1)) begin
          pass_d  = pass_q + 1'b1;
          count_d = CNT_INIT;
        end else                              state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      count_q <= CNT_INIT;
      pass_q  <= '0;
      tick_q  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= btn_start;
      pause_q <= btn_pause;
      count_q <= count_d;
      pass_q  <= pass_d;
      tick_q  <= tick_d;
      running <= (state_d == ST_RUN);
      done    <= (state_d == ST_DONE);
    end
  end

  // Per-digit nibble: countdown field on top, static pattern below.
  for (genvar k = 0; k < CNT_DIGITS; k++) begin : g_lz
    if (k == 0) begin : g_lsd
      assign lz_blank[k] = 1'b0;
    end else begin : g_hi
      assign lz_blank[k] = BLANK_LZ && (count_q[CW-1:4*k] == '0);
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_nib
    if (d >= LO) begin : g_cnt
      assign disp_nib[d] = lz_blank[d-LO] ? 4'hF : count_q[4*(d-LO) +: 4];
    end else begin : g_static
      assign disp_nib[d] = STATIC_BCD[4*d +: 4];
    end
  end

  assign entering = (state_q == ST_IDLE) && start_e;
  assign scan_act = (state_q != ST_IDLE);
  assign load     = entering || (scan_act && scan_q == SW'(SCAN_CYCLES - 1));
  assign nxt_idx  = (entering || dig_q == '0) ? DW'(NUM_DIGITS - 1) : dig_q - 1'b1;
  assign sel_nib  = disp_nib[nxt_idx];

  seg7_decode u_dec (
    .nib (sel_nib),
    .seg (sel_seg)
  );

  // Enable, segments and dp load together only at a digit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_en  <= '1;
      led_seg <= SEG_BLANK;
      led_dp  <= 1'b1;
      dig_q   <= '0;
      scan_q  <= '0;
    end else if (load) begin
      led_en  <= ~(NUM_DIGITS'(1) << nxt_idx);
      led_seg <= sel_seg;
      led_dp  <= ~DP_MASK[nxt_idx];
      dig_q   <= nxt_idx;
      scan_q  <= '0;
    end else if (scan_act) begin
      scan_q  <= scan_q + 1'b1;
    end else begin
      led_en  <= '1;
      led_seg <= SEG_BLANK;
      led_dp  <= 1'b1;
    end
  end

endmodule
